// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, receiver FSM encoding, vote helper
// and status error-bit positions used by the receiver, transmitter and status block.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } uart_state_e;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_BREAK   = 3;
    localparam int ERR_W       = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div_i and strobes tick_o on the terminal count.
// clr_i restarts the count so the first tick lands a full period after the clear.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = (cnt_q == div_i);

    // Free-running divider counter with synchronous restart.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote, glitch-rejecting start,
// programmable parity/stop bits, one-entry valid/ready holding register and error pulses.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic                 err_break,
    output logic                 busy
);

    localparam int IDX_W = $clog2(OVS);
    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVS/2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVS/2);
    localparam logic [IDX_W-1:0] IDX_DEC  = IDX_W'(OVS/2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

    logic rx_meta_q, rx_sync_q;
    uart_state_e state_q;
    logic [DIV_W-1:0] div_l_q;
    logic [1:0] par_l_q;
    logic stop2_l_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0] samp_q;
    logic [3:0] bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic par_bit_q;
    logic [DATA_BITS-1:0] m_data_q;
    logic m_valid_q;
    logic [ERR_W-1:0] err_q;

    logic start_s, tick_s, dec_s, bit_s, par_en_s, par_bad_s, fin_s, brk_s, good_s;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rstb   (rstb),
        .clr_i  (start_s),
        .div_i  (div_l_q),
        .tick_o (tick_s)
    );

    // Two-flop synchronizer, idle-high after reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Bit decision and end-of-frame classification.
    always_comb begin
        start_s   = (state_q == ST_IDLE) && !rx_sync_q;
        dec_s     = tick_s && (idx_q == IDX_DEC);
        bit_s     = maj3(samp_q[0], samp_q[1], rx_sync_q);
        par_en_s  = (par_l_q == PAR_EVEN) || (par_l_q == PAR_ODD);
        par_bad_s = par_en_s && (((^shift_q) ^ par_bit_q) != (par_l_q == PAR_ODD));
        fin_s     = dec_s && (((state_q == ST_STOP1) && !(bit_s && stop2_l_q)) ||
                              (state_q == ST_STOP2));
        // A break can only be recognised on the first stop bit.
        brk_s     = (state_q == ST_STOP1) && !bit_s && (shift_q == '0) &&
                    !(par_en_s && par_bit_q);
        good_s    = fin_s && bit_s && !par_bad_s;
    end

    // Receiver FSM with registered word, handshake and error pulses.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= ST_IDLE;
            div_l_q   <= '0;
            par_l_q   <= PAR_NONE;
            stop2_l_q <= 1'b0;
            idx_q     <= '0;
            samp_q    <= 2'b11;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= '0;
        end else begin
            err_q[ERR_FRAME]   <= fin_s && !brk_s && !bit_s;
            err_q[ERR_PARITY]  <= fin_s && !brk_s && par_bad_s;
            err_q[ERR_BREAK]   <= fin_s && brk_s;
            err_q[ERR_OVERRUN] <= good_s && m_valid_q && !m_ready;

            if (good_s && (!m_valid_q || m_ready)) begin
                m_data_q  <= shift_q;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end else begin
                m_valid_q <= m_valid_q;
            end

            if (start_s) begin
                div_l_q   <= cfg_div;
                par_l_q   <= cfg_parity;
                stop2_l_q <= cfg_stop2;
                idx_q     <= '0;
                bit_cnt_q <= 4'd0;
                par_bit_q <= 1'b0;
                state_q   <= ST_START;
            end else if (state_q == ST_WAIT_HIGH) begin
                state_q <= rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
            end else if (tick_s && (state_q != ST_IDLE)) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                if (idx_q == IDX_S0) samp_q[0] <= rx_sync_q;
                if (idx_q == IDX_S1) samp_q[1] <= rx_sync_q;
                if (dec_s) begin
                    case (state_q)
                        ST_START:  state_q <= bit_s ? ST_IDLE : ST_DATA;
                        ST_DATA: begin
                            shift_q <= {bit_s, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= par_en_s ? ST_PARITY : ST_STOP1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                        ST_PARITY: begin
                            par_bit_q <= bit_s;
                            state_q   <= ST_STOP1;
                        end
                        ST_STOP1: begin
                            if (bit_s && stop2_l_q) state_q <= ST_STOP2;
                            else if (bit_s)         state_q <= ST_IDLE;
                            else                    state_q <= ST_WAIT_HIGH;
                        end
                        ST_STOP2:  state_q <= bit_s ? ST_IDLE : ST_WAIT_HIGH;
                        default:   state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign err_frame   = err_q[ERR_FRAME];
    assign err_parity  = err_q[ERR_PARITY];
    assign err_overrun = err_q[ERR_OVERRUN];
    assign err_break   = err_q[ERR_BREAK];
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8-bit instance for the main cases plus a
// 7-bit instance for 7O2 framing.
module tb_uart_rx_ovs;

    logic clk = 1'b0, rstb = 1'b0, rx = 1'b1, rx7 = 1'b1, m_ready = 1'b1, stop2 = 1'b0;
    logic [15:0] cfg_div = 16'd3;
    logic [1:0]  cfg_par = 2'd0;
    logic [7:0]  m_data;
    logic        m_valid, e_fr, e_pa, e_ov, e_bk, busy;
    logic [6:0]  m_data7;
    logic        m_valid7, e7_fr, e7_pa, e7_ov, e7_bk, busy7;

    int checks = 0, failures = 0, cyc = 0, vcyc = 0, n_long = 0;
    int n_acc = 0, n_fr = 0, n_pa = 0, n_ov = 0, n_bk = 0;
    int b_acc = 0, b_fr = 0, b_pa = 0, b_ov = 0, b_bk = 0;
    int n7_acc = 0, n7_fr = 0, n7_pa = 0;
    logic [7:0] last_d = 8'd0;
    logic [6:0] last7 = 7'd0;
    logic [3:0] prev_err = 4'd0;

    always #5 clk = ~clk;

    uart_rx_ovs #(.DATA_BITS(8), .OVS(16), .DIV_W(16)) dut (
        .clk(clk), .rstb(rstb), .rx(rx), .cfg_div(cfg_div), .cfg_parity(cfg_par),
        .cfg_stop2(stop2), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_frame(e_fr), .err_parity(e_pa), .err_overrun(e_ov), .err_break(e_bk),
        .busy(busy));

    uart_rx_ovs #(.DATA_BITS(7), .OVS(16), .DIV_W(16)) dut7 (
        .clk(clk), .rstb(rstb), .rx(rx7), .cfg_div(cfg_div), .cfg_parity(cfg_par),
        .cfg_stop2(stop2), .m_data(m_data7), .m_valid(m_valid7), .m_ready(1'b1),
        .err_frame(e7_fr), .err_parity(e7_pa), .err_overrun(e7_ov), .err_break(e7_bk),
        .busy(busy7));

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            n_acc  <= n_acc + 1;
            last_d <= m_data;
            vcyc   <= cyc;
        end
        n_fr <= n_fr + int'(e_fr);
        n_pa <= n_pa + int'(e_pa);
        n_ov <= n_ov + int'(e_ov);
        n_bk <= n_bk + int'(e_bk);
        prev_err <= {e_fr, e_pa, e_ov, e_bk};
        if (({e_fr, e_pa, e_ov, e_bk} & prev_err) != 4'd0) n_long <= n_long + 1;
        if (m_valid7) begin
            n7_acc <= n7_acc + 1;
            last7  <= m_data7;
        end
        n7_fr <= n7_fr + int'(e7_fr);
        n7_pa <= n7_pa + int'(e7_pa);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 m_ready = v;
    endtask

    task automatic snap();
        b_acc = n_acc; b_fr = n_fr; b_pa = n_pa; b_ov = n_ov; b_bk = n_bk;
    endtask

    function automatic int err_delta();
        return (n_fr - b_fr) + (n_pa - b_pa) + (n_ov - b_ov) + (n_bk - b_bk);
    endfunction

    task automatic line(input logic use7, input logic v);
        if (use7) rx7 = v;
        else rx = v;
    endtask

    // One frame; fin_high=0 leaves the line at the last stop level.
    task automatic send(input int nb, input logic [8:0] d, input logic has_par,
                        input logic pbit, input logic s1, input int nstop, input logic s2,
                        input int bclk, input logic use7, input logic fin_high);
        line(use7, 1'b0); wait_clk(bclk);
        for (int i = 0; i < nb; i++) begin
            line(use7, d[i]); wait_clk(bclk);
        end
        if (has_par) begin
            line(use7, pbit); wait_clk(bclk);
        end
        line(use7, s1); wait_clk(bclk);
        if (nstop == 2) begin
            line(use7, s2); wait_clk(bclk);
        end
        if (fin_high) line(use7, 1'b1);
    endtask

    initial begin
        int c0;
        wait_clk(3);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'({e_fr, e_pa, e_ov, e_bk}), 0);
        rstb = 1'b1;
        wait_clk(5);

        // 8N1 0xA5 with latency check
        snap(); c0 = cyc;
        send(8, 9'h0A5, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1);
        wait_clk(128);
        chk("a5_acc", n_acc - b_acc, 1);
        chk("a5_data", int'(last_d), 'hA5);
        chk("a5_latency", vcyc - c0, 619);
        chk("a5_err", err_delta(), 0);

        // Even then odd parity on 0x03
        cfg_par = 2'd1; snap();
        send(8, 9'h003, 1'b1, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("even_ok_acc", n_acc - b_acc, 1);
        chk("even_ok_data", int'(last_d), 'h03);
        snap();
        send(8, 9'h003, 1'b1, 1'b1, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("even_bad_par", n_pa - b_pa, 1);
        chk("even_bad_acc", n_acc - b_acc, 0);
        cfg_par = 2'd2; snap();
        send(8, 9'h003, 1'b1, 1'b1, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("odd_ok_acc", n_acc - b_acc, 1);
        chk("odd_ok_err", err_delta(), 0);
        snap();
        send(8, 9'h003, 1'b1, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("odd_bad_par", n_pa - b_pa, 1);
        chk("odd_bad_acc", n_acc - b_acc, 0);
        cfg_par = 2'd0;

        // Start glitch of one tick
        snap();
        rx = 1'b0; wait_clk(4); rx = 1'b1; wait_clk(6);
        chk("glitch_busy_start", int'(busy), 1);
        wait_clk(100);
        chk("glitch_busy_end", int'(busy), 0);
        chk("glitch_err", err_delta(), 0);
        chk("glitch_acc", n_acc - b_acc, 0);

        // Framing error holds in WAIT_HIGH while the line stays low
        snap();
        send(8, 9'h055, 1'b0, 1'b0, 1'b0, 1, 1'b1, 64, 1'b0, 1'b0);
        wait_clk(200);
        chk("frame_wait_busy", int'(busy), 1);
        chk("frame_err", n_fr - b_fr, 1);
        chk("frame_acc", n_acc - b_acc, 0);
        rx = 1'b1; wait_clk(10);
        chk("frame_idle", int'(busy), 0);

        // Break followed by a clean frame
        snap();
        rx = 1'b0; wait_clk(20 * 64);
        chk("break_busy", int'(busy), 1);
        rx = 1'b1; wait_clk(100);
        chk("break_pulse", n_bk - b_bk, 1);
        chk("break_no_frame", n_fr - b_fr, 0);
        chk("break_acc", n_acc - b_acc, 0);
        snap();
        send(8, 9'h03C, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("after_break_acc", n_acc - b_acc, 1);
        chk("after_break_data", int'(last_d), 'h3C);

        // Overrun with consumer stalled
        set_ready(1'b0); snap();
        send(8, 9'h011, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        send(8, 9'h022, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("ovr_valid", int'(m_valid), 1);
        chk("ovr_data", int'(m_data), 'h11);
        chk("ovr_pulse", n_ov - b_ov, 1);
        set_ready(1'b1); wait_clk(2);
        chk("ovr_accept", n_acc - b_acc, 1);
        chk("ovr_accept_data", int'(last_d), 'h11);
        chk("ovr_valid_clr", int'(m_valid), 0);

        // Divisor change mid-frame applies to the following frame
        snap();
        fork
            send(8, 9'h096, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1);
            begin wait_clk(300); cfg_div = 16'd7; end
        join
        wait_clk(64);
        chk("div_cur_acc", n_acc - b_acc, 1);
        chk("div_cur_data", int'(last_d), 'h96);
        snap();
        send(8, 9'h069, 1'b0, 1'b0, 1'b1, 1, 1'b1, 128, 1'b0, 1'b1); wait_clk(128);
        chk("div_next_acc", n_acc - b_acc, 1);
        chk("div_next_data", int'(last_d), 'h69);
        cfg_div = 16'd3;

        // 7O2 on the 7-bit instance
        cfg_par = 2'd2; stop2 = 1'b1;
        send(7, 9'h05A, 1'b1, 1'b1, 1'b1, 2, 1'b1, 64, 1'b1, 1'b1); wait_clk(64);
        chk("7o2_acc", n7_acc, 1);
        chk("7o2_data", int'(last7), 'h5A);
        chk("7o2_no_frame", n7_fr, 0);
        send(7, 9'h05A, 1'b1, 1'b1, 1'b1, 2, 1'b0, 64, 1'b1, 1'b1); wait_clk(64);
        chk("7o2_stop2_frame", n7_fr, 1);
        chk("7o2_stop2_acc", n7_acc, 1);
        chk("7o2_no_parity", n7_pa, 0);
        cfg_par = 2'd0; stop2 = 1'b0;

        // Reset mid-DATA with a held word
        set_ready(1'b0); snap();
        send(8, 9'h077, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1); wait_clk(64);
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), 'h77);
        fork
            send(8, 9'h0F0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 64, 1'b0, 1'b1);
            begin
                wait_clk(200);
                chk("pre_rst_busy", int'(busy), 1);
                rstb = 1'b0; wait_clk(2);
                chk("midrst_valid", int'(m_valid), 0);
                chk("midrst_data", int'(m_data), 0);
                chk("midrst_busy", int'(busy), 0);
                chk("midrst_err", int'({e_fr, e_pa, e_ov, e_bk}), 0);
            end
        join
        wait_clk(10); rstb = 1'b1; wait_clk(50);
        chk("post_rst_busy", int'(busy), 0);
        chk("pulse_width", n_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
